// File: rtl/register_writeback_if.sv
// register_writeback_if: load/ALU result inputs, register-file and PC write-back
// outputs, and the pending-destination scoreboard of register_writeback.
interface register_writeback_if;
   logic        mem_valid_i;
   logic [4:0]  mem_dest_i;
   logic [31:0] mem_value_i;
   logic        mem_ready_o;
   logic        alu_valid_i;
   logic [4:0]  alu_dest_i;
   logic [31:0] alu_value_i;
   logic        alu_ready_o;
   logic [4:0]  select_write_o;
   logic        write_enable_o;
   logic [31:0] write_value_o;
   logic        pc_write_o;
   logic [31:0] pc_value_o;
   logic [31:0] pending_o;
   modport master (
      output mem_valid_i, mem_dest_i, mem_value_i, alu_valid_i, alu_dest_i, alu_value_i,
      input  mem_ready_o, alu_ready_o, select_write_o, write_enable_o, write_value_o,
             pc_write_o, pc_value_o, pending_o
   );
   modport slave (
      input  mem_valid_i, mem_dest_i, mem_value_i, alu_valid_i, alu_dest_i, alu_value_i,
      output mem_ready_o, alu_ready_o, select_write_o, write_enable_o, write_value_o,
             pc_write_o, pc_value_o, pending_o
   );
endinterface

// File: rtl/register_writeback.sv
// register_writeback: DEPTH-entry write-back FIFO merging load and ALU results,
// draining one register (or PC) write per cycle with a pending-destination scoreboard.
module register_writeback #(
   parameter int DEPTH = 4
) (
   input logic                 clock_i,
   input logic                 reset_n_i,
   register_writeback_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] C_PAIR = (AW+1)'(DEPTH - 2);
   logic [4:0]    r_dest  [DEPTH];
   logic [31:0]   r_value [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_mem_push;
   logic          w_alu_push;
   logic          w_pop;
   logic [AW-1:0] w_alu_slot;
   logic [4:0]    w_head_dest;
   logic [31:0]   w_head_value;
   logic          w_head_pc;
   logic [31:0]   w_pending;
   // ALU may only take the last free slot when the load port cannot claim it
   assign bus.mem_ready_o = r_count < C_FULL;
   assign bus.alu_ready_o = (r_count <= C_PAIR) || ((r_count == C_LAST) && !bus.mem_valid_i);
   assign w_mem_push = bus.mem_valid_i && bus.mem_ready_o && (bus.mem_dest_i != 5'd0);
   assign w_alu_push = bus.alu_valid_i && bus.alu_ready_o && (bus.alu_dest_i != 5'd0);
   assign w_pop      = r_count != '0;
   assign w_alu_slot = r_wr_ptr + AW'(w_mem_push);
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_mem_push) + AW'(w_alu_push);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_count  <= r_count + (AW+1)'(w_mem_push) + (AW+1)'(w_alu_push) - (AW+1)'(w_pop);
      end
   end
   // Storage needs no reset: every read of it is qualified by r_count
   always_ff @(posedge clock_i) begin
      if (w_mem_push) begin
         r_dest[r_wr_ptr]  <= bus.mem_dest_i;
         r_value[r_wr_ptr] <= bus.mem_value_i;
      end
      if (w_alu_push) begin
         r_dest[w_alu_slot]  <= bus.alu_dest_i;
         r_value[w_alu_slot] <= bus.alu_value_i;
      end
   end
   assign w_head_dest  = w_pop ? r_dest[r_rd_ptr] : 5'd0;
   assign w_head_value = w_pop ? r_value[r_rd_ptr] : 32'd0;
   assign w_head_pc    = w_pop && (w_head_dest == 5'd31);
   assign bus.write_enable_o = w_pop && !w_head_pc;
   assign bus.select_write_o = bus.write_enable_o ? w_head_dest : 5'd0;
   assign bus.write_value_o  = bus.write_enable_o ? w_head_value : 32'd0;
   assign bus.pc_write_o     = w_head_pc;
   assign bus.pc_value_o     = w_head_pc ? w_head_value : 32'd0;
   // A slot is live when its distance from the read pointer is below the occupancy
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < DEPTH; i++)
         if ({1'b0, AW'(i) - r_rd_ptr} < r_count) w_pending[r_dest[i]] = 1'b1;
      w_pending[0] = 1'b0;
   end
   assign bus.pending_o = w_pending;
endmodule

// File: tb/tb_register_writeback.sv
// tb_register_writeback: randomized and directed stimulus checked every cycle
// against a queue-based model of the write-back FIFO.
module tb_register_writeback;
   localparam int DEPTH = 4;
   typedef struct packed { logic [4:0] d; logic [31:0] v; } ent_t;
   logic clock_i = 1'b0;
   logic reset_n_i = 1'b0;
   register_writeback_if bus();
   register_writeback #(.DEPTH(DEPTH)) dut (.clock_i(clock_i), .reset_n_i(reset_n_i), .bus(bus));
   ent_t        q[$];
   logic [4:0]  wlog[$];
   bit          logw = 1'b0;
   bit          m_acc, a_acc;
   logic [31:0] e_pend;
   int          n_chk = 0;
   int          n_pass = 0;
   bit          mv, av, macc, aacc;
   logic [4:0]  md, ad;
   logic [31:0] mval, aval;
   int          mi, ai;
   logic [4:0]  exp_ord [12] = '{5'd1, 5'd7, 5'd2, 5'd8, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10, 5'd11, 5'd12};
   always #10 clock_i = ~clock_i;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask
   function automatic bit exp_aready();
      return (q.size() <= DEPTH - 2) || (q.size() == DEPTH - 1 && !bus.mem_valid_i);
   endfunction
   task automatic drive(input bit v0, input logic [4:0] d0, input logic [31:0] x0,
                        input bit v1, input logic [4:0] d1, input logic [31:0] x1);
      bus.mem_valid_i = v0; bus.mem_dest_i = d0; bus.mem_value_i = x0;
      bus.alu_valid_i = v1; bus.alu_dest_i = d1; bus.alu_value_i = x1;
   endtask
   task automatic tick();
      @(negedge clock_i);
   endtask
   function automatic logic [4:0] pick_dest();
      int r = $urandom_range(0, 9);
      return (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(1, 30));
   endfunction
   // Model: FIFO of accepted non-zero destinations; head is written each edge
   always @(negedge reset_n_i) q.delete();
   always @(posedge clock_i) begin
      if (reset_n_i) begin
         m_acc = bus.mem_valid_i && (q.size() < DEPTH);
         a_acc = bus.alu_valid_i && exp_aready();
         if (q.size() != 0) begin
            if (logw) wlog.push_back(q[0].d);
            void'(q.pop_front());
         end
         if (m_acc && bus.mem_dest_i != 5'd0) q.push_back({bus.mem_dest_i, bus.mem_value_i});
         if (a_acc && bus.alu_dest_i != 5'd0) q.push_back({bus.alu_dest_i, bus.alu_value_i});
      end
   end
   always @(negedge clock_i) begin
      #2;
      e_pend = '0;
      foreach (q[i]) e_pend[q[i].d] = 1'b1;
      chk("mem_ready", bus.mem_ready_o, q.size() < DEPTH);
      chk("alu_ready", bus.alu_ready_o, exp_aready());
      chk("pending", bus.pending_o, e_pend);
      if (q.size() == 0) begin
         chk("idle_we", bus.write_enable_o, 0);
         chk("idle_pcw", bus.pc_write_o, 0);
         chk("idle_sel", bus.select_write_o, 0);
         chk("idle_wv", bus.write_value_o, 0);
         chk("idle_pcv", bus.pc_value_o, 0);
      end else if (q[0].d == 5'd31) begin
         chk("pc_we", bus.write_enable_o, 0);
         chk("pc_pcw", bus.pc_write_o, 1);
         chk("pc_pcv", bus.pc_value_o, q[0].v);
      end else begin
         chk("rf_we", bus.write_enable_o, 1);
         chk("rf_pcw", bus.pc_write_o, 0);
         chk("rf_sel", bus.select_write_o, 32'(q[0].d));
         chk("rf_wv", bus.write_value_o, q[0].v);
      end
   end
   initial begin
      drive(0, 0, 0, 0, 0, 0);
      #3;
      chk("rst_mready", bus.mem_ready_o, 1);
      chk("rst_aready", bus.alu_ready_o, 1);
      chk("rst_we", bus.write_enable_o, 0);
      chk("rst_pend", bus.pending_o, 0);
      tick();
      reset_n_i = 1'b1;
      // single ALU write
      tick(); drive(0, 0, 0, 1, 5, 32'h1234);
      tick(); drive(0, 0, 0, 0, 0, 0); #3;
      chk("t1_we", bus.write_enable_o, 1);
      chk("t1_sel", bus.select_write_o, 5);
      chk("t1_wv", bus.write_value_o, 32'h1234);
      chk("t1_pend", bus.pending_o, 32'h20);
      tick(); #3;
      chk("t1_we_after", bus.write_enable_o, 0);
      chk("t1_pend_after", bus.pending_o, 0);
      // load ahead of ALU to the same register
      tick(); drive(1, 3, 32'hA, 1, 3, 32'hB);
      tick(); drive(0, 0, 0, 0, 0, 0); #3;
      chk("t2_first", bus.write_value_o, 32'hA);
      chk("t2_pend1", bus.pending_o, 32'h8);
      tick(); #3;
      chk("t2_second", bus.write_value_o, 32'hB);
      chk("t2_pend2", bus.pending_o, 32'h8);
      tick(); #3;
      chk("t2_pend3", bus.pending_o, 0);
      // dest 0 discarded, dest 31 goes to PC
      tick(); drive(0, 0, 0, 1, 0, 32'hFFFF); #1;
      chk("t4_r0_ready", bus.alu_ready_o, 1);
      tick(); drive(0, 0, 0, 0, 0, 0); #3;
      chk("t4_r0_we", bus.write_enable_o, 0);
      chk("t4_r0_pend", bus.pending_o, 0);
      tick(); drive(0, 0, 0, 1, 31, 32'h100);
      tick(); drive(0, 0, 0, 0, 0, 0); #3;
      chk("t4_pcw", bus.pc_write_o, 1);
      chk("t4_pcv", bus.pc_value_o, 32'h100);
      chk("t4_we", bus.write_enable_o, 0);
      chk("t4_pend", bus.pending_o, 32'h8000_0000);
      // both sources streaming: order and back-pressure
      tick(); logw = 1'b1; mi = 0; ai = 0;
      for (int c = 0; c < 40 && (mi < 6 || ai < 6); c++) begin
         drive(mi < 6, 5'(mi + 1), 32'h100 + mi, ai < 6, 5'(ai + 7), 32'h200 + ai); #1;
         macc = (mi < 6) && bus.mem_ready_o;
         aacc = (ai < 6) && bus.alu_ready_o;
         tick();
         mi += int'(macc); ai += int'(aacc);
      end
      drive(0, 0, 0, 0, 0, 0);
      repeat (5) tick();
      logw = 1'b0;
      chk("t3_accepted", mi + ai, 12);
      chk("t3_writes", wlog.size(), 12);
      foreach (exp_ord[i]) chk("t3_order", (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEAD, 32'(exp_ord[i]));
      // fill, then asynchronous reset between edges
      drive(1, 1, 32'h11, 1, 2, 32'h22);
      tick(); drive(1, 3, 32'h33, 1, 4, 32'h44);
      tick(); drive(0, 0, 0, 0, 0, 0); #3;
      chk("t5_full_pend", bus.pending_o, 32'h1C);
      chk("t5_full_sel", bus.select_write_o, 2);
      #1 reset_n_i = 1'b0;
      #1;
      chk("t5_rst_we", bus.write_enable_o, 0);
      chk("t5_rst_sel", bus.select_write_o, 0);
      chk("t5_rst_wv", bus.write_value_o, 0);
      chk("t5_rst_pend", bus.pending_o, 0);
      chk("t5_rst_mready", bus.mem_ready_o, 1);
      chk("t5_rst_aready", bus.alu_ready_o, 1);
      #1 reset_n_i = 1'b1;
      tick(); #3;
      chk("t5_after_we", bus.write_enable_o, 0);
      chk("t5_after_pend", bus.pending_o, 0);
      tick(); drive(0, 0, 0, 1, 9, 32'h99);
      tick(); drive(0, 0, 0, 0, 0, 0); #3;
      chk("t5_resume_sel", bus.select_write_o, 9);
      // random traffic, sources hold refused data
      mv = 0; av = 0; macc = 0; aacc = 0;
      for (int c = 0; c < 500; c++) begin
         tick();
         if (!mv || macc) begin
            mv = $urandom_range(0, 2) != 0; md = pick_dest(); mval = $urandom;
         end
         if (!av || aacc) begin
            av = $urandom_range(0, 2) != 0; ad = pick_dest(); aval = $urandom;
         end
         drive(mv, md, mval, av, ad, aval); #1;
         macc = mv && bus.mem_ready_o;
         aacc = av && bus.alu_ready_o;
      end
      tick(); drive(0, 0, 0, 0, 0, 0);
      repeat (6) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
